// File: rtl/nic_link_allocator_pkg.sv
// Shared types and default sizing for the NiC link-allocation stage.
package nic_link_allocator_pkg;

  // Default geometry of the fifo_out_buffer array feeding the nic2noc link.
  localparam int LA_N_FIFO_OUT_BUFFER      = 6;
  localparam int LA_N_BITS_FIFO_OUT_BUFFER = 3;
  localparam int LA_MAX_BURST              = 4;
  localparam int LA_N_BITS_BURST           = 3;

  // Link ownership: nobody holds a tenure, or an owner is mid-burst.
  typedef enum logic [0:0] {
    LA_IDLE  = 1'b0,
    LA_OWNED = 1'b1
  } la_state_e;

endpackage

// File: rtl/nic_link_allocator_rr_picker.sv
// Combinational round-robin priority picker: first set request at or after
// start_i, wrapping modulo N (not modulo 2**NB). Shared with the VC allocator.
module rr_priority_picker #(
  parameter int N  = 6,
  parameter int NB = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [NB-1:0] start_i,
  output logic          found_o,
  output logic [NB-1:0] id_o,
  output logic [N-1:0]  onehot_o
);

  // Scan N positions from start_i, wrapping at N, and keep the first hit.
  always_comb begin : pick_b
    logic [NB:0]   idx;
    logic          hit;
    logic [NB-1:0] hit_id;
    logic [N-1:0]  hit_oh;
    hit    = 1'b0;
    hit_id = {NB{1'b0}};
    hit_oh = {N{1'b0}};
    idx    = {(NB+1){1'b0}};
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, start_i} + (NB+1)'(k);
      if (idx >= (NB+1)'(N)) begin
        idx = idx - (NB+1)'(N);
      end else begin
        idx = idx;
      end
      if (!hit && req_i[idx[NB-1:0]]) begin
        hit                 = 1'b1;
        hit_id              = idx[NB-1:0];
        hit_oh[idx[NB-1:0]] = 1'b1;
      end else begin
        hit = hit;
      end
    end
    found_o  = hit;
    id_o     = hit_id;
    onehot_o = hit_oh;
  end

endmodule

// File: rtl/nic_link_allocator.sv
// Link allocator for the NiC output path: round-robin among fifo_out_buffers
// with a bounded burst tenure. Grants are same-cycle; sel_* is the grant
// delayed by one cycle and steers the flit mux onto nic2noc.
module nic_link_allocator
  import nic_link_allocator_pkg::*;
#(
  parameter int N_FIFO_OUT_BUFFER      = LA_N_FIFO_OUT_BUFFER,
  parameter int N_BITS_FIFO_OUT_BUFFER = LA_N_BITS_FIFO_OUT_BUFFER,
  parameter int MAX_BURST              = LA_MAX_BURST,
  parameter int N_BITS_BURST           = LA_N_BITS_BURST
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_FIFO_OUT_BUFFER-1:0]      r_la_i,
  input  logic                              link_stall_i,
  output logic                              g_la_o,
  output logic [N_BITS_FIFO_OUT_BUFFER-1:0] g_la_fifo_out_buffer_id_o,
  output logic [N_FIFO_OUT_BUFFER-1:0]      g_la_onehot_o,
  output logic                              sel_valid_o,
  output logic [N_BITS_FIFO_OUT_BUFFER-1:0] sel_id_o
);

  localparam int N  = N_FIFO_OUT_BUFFER;
  localparam int NB = N_BITS_FIFO_OUT_BUFFER;
  localparam int NC = N_BITS_BURST;

  la_state_e     state_q, state_d;
  logic [NB-1:0] ptr_q, ptr_d;
  logic [NB-1:0] owner_q, owner_d;
  logic [NC-1:0] cnt_q, cnt_d;
  logic          sel_valid_q, sel_valid_d;
  logic [NB-1:0] sel_id_q, sel_id_d;

  logic          grant_s;
  logic [NB-1:0] grant_id_s;
  logic [N-1:0]  grant_oh_s;

  logic          pick_found_s;
  logic [NB-1:0] pick_id_s;
  logic [N-1:0]  pick_oh_s;

  rr_priority_picker #(
    .N  (N),
    .NB (NB)
  ) u_picker (
    .req_i    (r_la_i),
    .start_i  (ptr_q),
    .found_o  (pick_found_s),
    .id_o     (pick_id_s),
    .onehot_o (pick_oh_s)
  );

  // Decide this cycle's grant (keep owner or re-arbitrate) and the next tenure state.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    grant_s    = 1'b0;
    grant_id_s = {NB{1'b0}};
    grant_oh_s = {N{1'b0}};
    if (rst) begin
      // Outputs quiet during reset; the register block clears the state.
      grant_s = 1'b0;
    end else if (link_stall_i) begin
      // Link busy: hold the tenure exactly where it is.
      grant_s = 1'b0;
    end else if ((state_q == LA_OWNED) && r_la_i[owner_q] && (cnt_q < NC'(MAX_BURST))) begin
      grant_s    = 1'b1;
      grant_id_s = owner_q;
      grant_oh_s = {{(N-1){1'b0}}, 1'b1} << owner_q;
      cnt_d      = cnt_q + NC'(1);
    end else if (pick_found_s) begin
      // New tenure; an expired sole requester simply wins again.
      grant_s    = 1'b1;
      grant_id_s = pick_id_s;
      grant_oh_s = pick_oh_s;
      owner_d    = pick_id_s;
      cnt_d      = NC'(1);
      state_d    = LA_OWNED;
      if (pick_id_s == NB'(N - 1)) begin
        ptr_d = {NB{1'b0}};
      end else begin
        ptr_d = pick_id_s + NB'(1);
      end
    end else begin
      state_d = LA_IDLE;
      cnt_d   = {NC{1'b0}};
    end
    sel_valid_d = grant_s;
    sel_id_d    = grant_id_s;
  end

  // Tenure state and the one-cycle-delayed flit select, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LA_IDLE;
      ptr_q       <= {NB{1'b0}};
      owner_q     <= {NB{1'b0}};
      cnt_q       <= {NC{1'b0}};
      sel_valid_q <= 1'b0;
      sel_id_q    <= {NB{1'b0}};
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      sel_valid_q <= sel_valid_d;
      sel_id_q    <= sel_id_d;
    end
  end

  assign g_la_o                    = grant_s;
  assign g_la_fifo_out_buffer_id_o = grant_id_s;
  assign g_la_onehot_o             = grant_oh_s;
  assign sel_valid_o               = sel_valid_q;
  assign sel_id_o                  = sel_id_q;

endmodule

// File: tb/tb_nic_link_allocator.sv
// Scoreboard bench for nic_link_allocator: a driver issues directed and random
// request patterns, a reference model pushes the expected per-cycle response,
// and a monitor on the falling edge pops and compares.
module tb_nic_link_allocator;

  localparam int N  = 6;
  localparam int NB = 3;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  r_la;
  logic          stall;
  logic          g_la;
  logic [NB-1:0] g_id;
  logic [N-1:0]  g_oh;
  logic          sel_valid;
  logic [NB-1:0] sel_id;

  always #5 clk = ~clk;

  nic_link_allocator #(
    .N_FIFO_OUT_BUFFER      (N),
    .N_BITS_FIFO_OUT_BUFFER (NB),
    .MAX_BURST              (MB),
    .N_BITS_BURST           (3)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .r_la_i                    (r_la),
    .link_stall_i              (stall),
    .g_la_o                    (g_la),
    .g_la_fifo_out_buffer_id_o (g_id),
    .g_la_onehot_o             (g_oh),
    .sel_valid_o               (sel_valid),
    .sel_id_o                  (sel_id)
  );

  typedef struct {
    logic          gv;
    logic [NB-1:0] gid;
    logic [N-1:0]  goh;
    logic          sv;
    logic [NB-1:0] sid;
    logic          chk_sel;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: who holds the link, for how many flits so far, and where
  // the next fair search begins; plus what the link carried last cycle.
  int   m_owner;
  int   m_used;     // flits granted in current tenure, 0 = no tenure
  int   m_start;
  bit   m_prev_v;
  int   m_prev_id;
  bit   m_prev_known = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // One cycle of stimulus: drive inputs just after the edge, predict, enqueue.
  task automatic step(input logic [N-1:0] r, input logic s, input logic rs);
    exp_t e;
    int   w;
    @(posedge clk);
    #1;
    r_la  = r;
    stall = s;
    rst   = rs;
    e.gv      = 1'b0;
    e.gid     = '0;
    e.goh     = '0;
    e.chk_sel = m_prev_known;
    e.sv      = m_prev_v;
    e.sid     = NB'(m_prev_id);
    if (rs) begin
      m_owner = 0;
      m_used  = 0;
      m_start = 0;
    end else if (!s) begin
      if (m_used > 0 && r[m_owner] && m_used < MB) begin
        e.gv   = 1'b1;
        e.gid  = NB'(m_owner);
        m_used = m_used + 1;
      end else begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          if (w < 0 && r[(m_start + k) % N]) w = (m_start + k) % N;
        end
        if (w >= 0) begin
          e.gv    = 1'b1;
          e.gid   = NB'(w);
          m_owner = w;
          m_used  = 1;
          m_start = (w + 1) % N;
        end else begin
          m_used = 0;
        end
      end
    end
    if (e.gv) e.goh = N'(1) << e.gid;
    m_prev_v     = e.gv;
    m_prev_id    = e.gv ? int'(e.gid) : 0;
    m_prev_known = 1'b1;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT against the oldest prediction, mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("g_la", 32'(g_la), 32'(e.gv));
        check("g_id", 32'(g_id), 32'(e.gid));
        check("g_onehot", 32'(g_oh), 32'(e.goh));
        if (e.chk_sel) begin
          check("sel_valid", 32'(sel_valid), 32'(e.sv));
          check("sel_id", 32'(sel_id), 32'(e.sid));
        end
      end
    end
  end

  // Hard time limit so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    logic [N-1:0] r;
    logic         s;
    logic         rs;
    rst   = 1'b1;
    r_la  = '0;
    stall = 1'b0;
    // Reset with everyone requesting, then saturation round-robin.
    step(6'b111111, 1'b0, 1'b1);
    step(6'b111111, 1'b0, 1'b1);
    repeat (26) step(6'b111111, 1'b0, 1'b0);
    // Owner drops after two grants: neighbour takes over with no bubble.
    step(6'b000011, 1'b0, 1'b1);
    repeat (2) step(6'b000011, 1'b0, 1'b0);
    repeat (3) step(6'b000010, 1'b0, 1'b0);
    // Wrap: grant 4 moves the search to 5, then 5 and 0 alternate.
    step(6'b000000, 1'b0, 1'b1);
    step(6'b010000, 1'b0, 1'b0);
    repeat (10) step(6'b100001, 1'b0, 1'b0);
    step(6'b000001, 1'b0, 1'b0);
    // Stall mid-tenure of owner 2.
    step(6'b000000, 1'b0, 1'b1);
    repeat (2) step(6'b000100, 1'b0, 1'b0);
    repeat (3) step(6'b000111, 1'b1, 1'b0);
    repeat (6) step(6'b000111, 1'b0, 1'b0);
    // Sole requester keeps winning across tenure expiry, and across a reset.
    repeat (10) step(6'b001000, 1'b0, 1'b0);
    step(6'b001000, 1'b0, 1'b1);
    repeat (6) step(6'b001000, 1'b0, 1'b0);
    // Random traffic with held request patterns, stalls and occasional reset.
    r = 6'b111111;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        if ($urandom_range(0, 3) == 0) r = N'(1) << $urandom_range(0, N - 1);
        else r = N'($urandom);
      end
      s  = ($urandom_range(0, 99) < 15);
      rs = ($urandom_range(0, 99) < 2);
      step(r, s, rs);
    end
    step(6'b000000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
